// File: rtl/pri_sched_pkg.sv
// Shared types, constants and the fixed-priority encoder for the
// request scheduler.
package pri_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Highest set bit wins; an all-zero vector returns 0.
    function automatic logic [2:0] prio8(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bcd7seg.sv
// BCD to active-low 7-segment decoder, output bit order {g,f,e,d,c,b,a}.
// Codes above 9 blank the digit.
module bcd7seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/pri_service_sched.sv
// Time-shares one priority encoder and one 7-segment digit among 8 sticky
// request lines; each grant is displayed for HOLD_CYCLES, then retired.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant; picks highest pending request when en = 1
// SHOW  | grant displayed; hold counter runs while en = 1
// DONE  | one-cycle retire of the granted pending bit, done pulse
module pri_service_sched
    import pri_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int CNT_W       = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] pending,
    output logic       cur_valid,
    output logic [2:0] cur_idx,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx_nxt;
    logic             valid_nxt;
    logic [7:0]       clr_mask;
    logic [6:0]       dig_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_idx   <= 3'd0;
            cur_valid <= 1'b0;
            pending   <= 8'h00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_idx   <= idx_nxt;
            cur_valid <= valid_nxt;
            // OR-ing req last lets a same-cycle re-request beat the retire.
            pending   <= (pending & ~clr_mask) | req;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = cur_idx;
        valid_nxt = cur_valid;
        clr_mask  = 8'h00;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (en && (pending != 8'h00)) begin
                    state_nxt = SHOW;
                    idx_nxt   = prio8(pending);
                    cnt_nxt   = '0;
                    valid_nxt = 1'b1;
                end
            end
            SHOW: begin
                if (en) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // Retire ignores en so a grant can never be left half-finished.
                done      = 1'b1;
                clr_mask  = 8'h01 << cur_idx;
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

    bcd7seg u_digit (
        .bcd (4'({1'b0, cur_idx})),
        .seg (dig_seg)
    );

    assign seg = cur_valid ? dig_seg : SEG_BLANK;

endmodule

// File: tb/tb_pri_service_sched.sv
// Directed bench for pri_service_sched with HOLD_CYCLES = 4.
module tb_pri_service_sched;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] pending;
    logic       cur_valid;
    logic [2:0] cur_idx;
    logic       busy;
    logic       done;
    logic [6:0] seg;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int t_done_a;
    int t_done_b;
    int t_grant;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;

    pri_service_sched #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .pending   (pending),
        .cur_valid (cur_valid),
        .cur_idx   (cur_idx),
        .busy      (busy),
        .done      (done),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_show(input string tag, input logic [2:0] idx, input logic [6:0] s);
        chk({tag, " valid"}, 32'(cur_valid), 32'd1);
        chk({tag, " idx"},   32'(cur_idx),   32'(idx));
        chk({tag, " seg"},   32'(seg),       32'(s));
        chk({tag, " done"},  32'(done),      32'd0);
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] pend);
        chk({tag, " valid"}, 32'(cur_valid), 32'd0);
        chk({tag, " busy"},  32'(busy),      32'd0);
        chk({tag, " seg"},   32'(seg),       32'(S_BLANK));
        chk({tag, " pend"},  32'(pending),   32'(pend));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        tick(2);
        chk("rst pend",  32'(pending),   32'h00);
        chk("rst valid", 32'(cur_valid), 32'd0);
        chk("rst idx",   32'(cur_idx),   32'd0);
        chk("rst busy",  32'(busy),      32'd0);
        chk("rst done",  32'(done),      32'd0);
        chk("rst seg",   32'(seg),       32'(S_BLANK));
        rst_n = 1'b1;
        tick(1);

        // async reset in the middle of a SHOW
        en  = 1'b1;
        req = 8'h24;
        tick(1);
        req = 8'h00;
        chk("a pend", 32'(pending), 32'h24);
        tick(1);
        chk_show("a grant", 3'd5, S5);
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        chk("a rst pend", 32'(pending),   32'h00);
        chk("a rst seg",  32'(seg),       32'(S_BLANK));
        chk("a rst busy", 32'(busy),      32'd0);
        chk("a rst done", 32'(done),      32'd0);
        chk("a rst vld",  32'(cur_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);

        // two requests served in priority order, done 6 cycles apart
        req = 8'h28;
        tick(1);
        req = 8'h00;
        chk("b pend", 32'(pending), 32'h28);
        chk("b vld0", 32'(cur_valid), 32'd0);
        tick(1);
        for (int i = 0; i < HOLD; i++) begin
            chk_show("b show5", 3'd5, S5);
            tick(1);
        end
        chk("b done5", 32'(done), 32'd1);
        chk("b busy5", 32'(busy), 32'd1);
        t_done_a = cyc;
        tick(1);
        chk_idle("b idle5", 8'h08);
        chk("b idx hold", 32'(cur_idx), 32'd5);
        tick(1);
        for (int i = 0; i < HOLD; i++) begin
            chk_show("b show3", 3'd3, S3);
            tick(1);
        end
        chk("b done3", 32'(done), 32'd1);
        t_done_b = cyc;
        chk("b spacing", 32'(t_done_b - t_done_a), 32'd6);
        tick(1);
        chk_idle("b idle3", 8'h00);

        // no preemption: req[7] arrives while idx 0 is shown
        req = 8'h01;
        tick(1);
        req = 8'h00;
        tick(1);
        chk_show("c show0 1", 3'd0, S0);
        tick(1);
        req = 8'h80;
        tick(1);
        req = 8'h00;
        chk("c pend81", 32'(pending), 32'h81);
        chk_show("c show0 3", 3'd0, S0);
        tick(1);
        chk_show("c show0 4", 3'd0, S0);
        tick(1);
        chk("c done0", 32'(done), 32'd1);
        chk("c done idx", 32'(cur_idx), 32'd0);
        tick(1);
        chk_idle("c idle", 8'h80);
        tick(1);
        chk_show("c show7", 3'd7, S7);
        tick(HOLD - 1);
        chk_show("c show7 last", 3'd7, S7);
        tick(1);
        chk("c done7", 32'(done), 32'd1);
        tick(1);
        chk_idle("c idle2", 8'h00);

        // en low stalls SHOW of idx 3; re-request in DONE keeps it pending
        req = 8'h08;
        tick(1);
        req = 8'h00;
        tick(1);
        t_grant = cyc;
        chk_show("d grant", 3'd3, S3);
        tick(1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_show("d stall", 3'd3, S3);
            chk("d stall busy", 32'(busy), 32'd1);
        end
        en = 1'b1;
        tick(2);
        chk_show("d resume", 3'd3, S3);
        tick(1);
        chk("d done", 32'(done), 32'd1);
        chk("d late", 32'(cyc - t_grant), 32'(HOLD + 3));
        req = 8'h08;
        tick(1);
        req = 8'h00;
        chk_idle("d setwins", 8'h08);
        tick(1);
        chk_show("d again", 3'd3, S3);
        tick(HOLD);
        chk("d done2", 32'(done), 32'd1);
        tick(1);
        chk_idle("d idle", 8'h00);

        // en low in IDLE: request latched but not granted
        en  = 1'b0;
        req = 8'h80;
        tick(1);
        req = 8'h00;
        tick(2);
        chk_idle("e hold", 8'h80);
        en = 1'b1;
        tick(1);
        chk_show("e grant", 3'd7, S7);
        chk("e busy", 32'(busy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
